// File: rtl/flappy_video_timing.sv
// Video timing generator for the Flappy Bird core: counters, sync/blank decode, renderer delay match.
// Optional FLAPPY_VT_BORDER_EN: forces white on the outermost active rows/columns.
module flappy_video_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic       Clk,
  input  logic       sys_reset,
  input  logic       ce_pix,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  input  logic [2:0] pix_rgb,
  output logic       frame_start,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic       vga_h_blank,
  output logic       vga_v_blank,
  output logic       vga_R,
  output logic       vga_G,
  output logic       vga_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1023 || V_TOTAL > 1023 || PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_params
    $error("flappy_video_timing: totals must fit in 10 bits and PIPE_DELAY must be 1..8");
  end

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Tap layout: [0] vblank, [1] hblank, [2] vsync, [3] hsync, [4] frame-edge (border build only)
`ifdef FLAPPY_VT_BORDER_EN
  localparam int TAP_W = 5;
  localparam logic [9:0] H_EDGE = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_EDGE = 10'(V_ACTIVE - 1);
`else
  localparam int TAP_W = 4;
`endif

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge Clk or negedge sys_reset) begin
    if (!sys_reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce_pix) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign pix_x       = h_cnt;
  assign pix_y       = v_cnt;
  assign frame_start = ce_pix & h_wrap & v_wrap;

  logic [TAP_W-1:0] raw;

  always_comb begin
    raw    = '0;
    raw[0] = (v_cnt >= V_ACT);
    raw[1] = (h_cnt >= H_ACT);
    raw[2] = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
    raw[3] = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
`ifdef FLAPPY_VT_BORDER_EN
    raw[4] = (h_cnt == 10'd0) || (h_cnt == H_EDGE) || (v_cnt == 10'd0) || (v_cnt == V_EDGE);
`endif
  end

  // din[i] is what tap i loads next; din[PIPE_DELAY-1] is the flag set that lands on the
  // outputs together with the colour sampled on the same enable.
  logic [TAP_W-1:0] taps [PIPE_DELAY];
  logic [TAP_W-1:0] din  [PIPE_DELAY];

  always_comb begin
    din[0] = raw;
    for (int i = 1; i < PIPE_DELAY; i++) begin
      din[i] = taps[i-1];
    end
  end

  always_ff @(posedge Clk or negedge sys_reset) begin
    if (!sys_reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        taps[i] <= '0;
      end
    end else if (ce_pix) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        taps[i] <= din[i];
      end
    end
  end

  logic [TAP_W-1:0] flags_next;
  logic [TAP_W-1:0] flags_out;
  logic [2:0]       rgb_next;
  logic [2:0]       rgb_q;

  assign flags_next = din[PIPE_DELAY-1];
  assign flags_out  = taps[PIPE_DELAY-1];

  always_comb begin
    rgb_next = pix_rgb;
`ifdef FLAPPY_VT_BORDER_EN
    if (flags_next[4]) rgb_next = 3'b111;
`endif
    if (flags_next[0] || flags_next[1]) rgb_next = 3'b000;
  end

  always_ff @(posedge Clk or negedge sys_reset) begin
    if (!sys_reset) begin
      rgb_q <= '0;
    end else if (ce_pix) begin
      rgb_q <= rgb_next;
    end
  end

  assign vga_v_blank = flags_out[0];
  assign vga_h_blank = flags_out[1];
  assign vga_v_sync  = flags_out[2];
  assign vga_h_sync  = flags_out[3];
  assign vga_R       = rgb_q[2];
  assign vga_G       = rgb_q[1];
  assign vga_B       = rgb_q[0];

endmodule

// File: tb/tb_flappy_video_timing.sv
// Bench for flappy_video_timing: default-timing instance (PIPE_DELAY=2) and a small-frame instance
// (PIPE_DELAY=5) driven by the same clock, reset and pixel enable, checked against an enable-count model.
module tb_flappy_video_timing;

  localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33, A_PD = 2;
  localparam int B_HA = 40,  B_HF = 4,  B_HS = 8,  B_HB = 4;
  localparam int B_VA = 20,  B_VF = 2,  B_VS = 2,  B_VB = 3,  B_PD = 5;
  localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
  localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
  localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VA + B_VF + B_VS + B_VB;

  // Hand-computed edges: instance A hsync (656+2 enables, 96 wide, period 800),
  // instance B vsync (22*56+5 enables, 112 wide, period 1512).
  localparam int LIT_K [12] = '{657, 658, 753, 754, 1457, 1458, 1236, 1237, 1348, 1349, 2748, 2749};
  localparam int LIT_V [12] = '{0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1};

  logic       Clk = 1'b0;
  logic       sys_reset;
  logic       ce_pix;
  logic [2:0] rgb_a, rgb_b;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_fs, a_hs, a_vs, a_hb, a_vb, a_r, a_g, a_b;
  logic       b_fs, b_hs, b_vs, b_hb, b_vb, b_r, b_g, b_b;

  always #5 Clk = ~Clk;

  flappy_video_timing #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB), .PIPE_DELAY(A_PD)
  ) u_a (
    .Clk(Clk), .sys_reset(sys_reset), .ce_pix(ce_pix),
    .pix_x(a_x), .pix_y(a_y), .pix_rgb(rgb_a), .frame_start(a_fs),
    .vga_h_sync(a_hs), .vga_v_sync(a_vs), .vga_h_blank(a_hb), .vga_v_blank(a_vb),
    .vga_R(a_r), .vga_G(a_g), .vga_B(a_b)
  );

  flappy_video_timing #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .PIPE_DELAY(B_PD)
  ) u_b (
    .Clk(Clk), .sys_reset(sys_reset), .ce_pix(ce_pix),
    .pix_x(b_x), .pix_y(b_y), .pix_rgb(rgb_b), .frame_start(b_fs),
    .vga_h_sync(b_hs), .vga_v_sync(b_vs), .vga_h_blank(b_hb), .vga_v_blank(b_vb),
    .vga_R(b_r), .vga_G(b_g), .vga_B(b_b)
  );

  int         k;           // enables accepted since reset release
  bit         const_mode;  // renderer outputs 3'b111 everywhere
  bit         checking;
  logic [2:0] f_a [1024];
  logic [2:0] f_b [1024];
  int         n_tests;
  int         n_fail;

  // Renderer: colour for the coordinate issued at enable e (coordinate 0 before the first enable).
  function automatic logic [2:0] rend(input bit sel, input int e);
    int x;
    if (e < 0) x = 0;
    else x = sel ? (e % B_HT) : (e % A_HT);
    if (const_mode) return 3'b111;
    return sel ? f_b[x] : f_a[x];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s k=%0d t=%0t: got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input bit sel,
                           input int ha, input int hf, input int hs, input int ht,
                           input int va, input int vf, input int vs, input int vt, input int pd,
                           input logic [9:0] ax, input logic [9:0] ay, input logic afs,
                           input logic ahs, input logic avs, input logic ahb, input logic avb,
                           input logic [2:0] argb);
    int e, ex, ey;
    bit hb, vb, hsy, vsy, fs;
    logic [2:0] exp_rgb;
    fs = ce_pix && (k % ht == ht - 1) && ((k / ht) % vt == vt - 1);
    chk({tag, "pix_x"}, ax, k % ht);
    chk({tag, "pix_y"}, ay, (k / ht) % vt);
    chk({tag, "frame_start"}, afs, fs);
    e = k - pd;
    hb = 0; vb = 0; hsy = 0; vsy = 0;
    exp_rgb = (k == 0) ? 3'b000 : rend(sel, e);
    if (e >= 0) begin
      ex  = e % ht;
      ey  = (e / ht) % vt;
      hb  = ex >= ha;
      vb  = ey >= va;
      hsy = (ex >= ha + hf) && (ex < ha + hf + hs);
      vsy = (ey >= va + vf) && (ey < va + vf + vs);
`ifdef FLAPPY_VT_BORDER_EN
      if (ex == 0 || ex == ha - 1 || ey == 0 || ey == va - 1) exp_rgb = 3'b111;
`endif
      if (hb || vb) exp_rgb = 3'b000;
    end
    chk({tag, "h_sync"}, ahs, hsy);
    chk({tag, "v_sync"}, avs, vsy);
    chk({tag, "h_blank"}, ahb, hb);
    chk({tag, "v_blank"}, avb, vb);
    chk({tag, "rgb"}, argb, exp_rgb);
  endtask

  // Compare process: every falling edge, both instances against the model, plus literal pins.
  always @(negedge Clk) begin
    if (checking) begin
      check_dut("a_", 1'b0, A_HA, A_HF, A_HS, A_HT, A_VA, A_VF, A_VS, A_VT, A_PD,
                a_x, a_y, a_fs, a_hs, a_vs, a_hb, a_vb, {a_r, a_g, a_b});
      check_dut("b_", 1'b1, B_HA, B_HF, B_HS, B_HT, B_VA, B_VF, B_VS, B_VT, B_PD,
                b_x, b_y, b_fs, b_hs, b_vs, b_hb, b_vb, {b_r, b_g, b_b});
      for (int i = 0; i < 12; i++) begin
        if (k == LIT_K[i]) begin
          if (i < 6) chk("lit_a_hsync", a_hs, LIT_V[i]);
          else       chk("lit_b_vsync", b_vs, LIT_V[i]);
        end
      end
      if (k == 57) begin
        chk("lit_b_x_after_wrap", b_x, 1);
        chk("lit_b_y_after_wrap", b_y, 1);
      end
      if (k == 1511 && ce_pix) chk("lit_b_frame_start", b_fs, 1);
    end
  end

  task automatic step(input bit ce_v);
    @(posedge Clk);
    if (sys_reset && ce_pix) k++;
    #1;
    ce_pix = ce_v;
    rgb_a  = ce_v ? rend(1'b0, k - (A_PD - 1)) : 3'($urandom_range(0, 7));
    rgb_b  = ce_v ? rend(1'b1, k - (B_PD - 1)) : 3'($urandom_range(0, 7));
  endtask

  initial begin
    sys_reset  = 1'b0;
    ce_pix     = 1'b0;
    rgb_a      = 3'b000;
    rgb_b      = 3'b000;
    k          = 0;
    const_mode = 1'b0;
    n_tests    = 0;
    n_fail     = 0;
    for (int i = 0; i < 1024; i++) begin
      f_a[i] = 3'($urandom_range(0, 7));
      f_b[i] = 3'($urandom_range(0, 7));
    end
    checking = 1'b1;
    repeat (5) @(posedge Clk);
    #1 sys_reset = 1'b1;

    // Steady enable: covers sync positions, widths and periods.
    for (int i = 0; i < 4000 && k < 3100; i++) step(1'b1);
    // One enable in four.
    for (int i = 0; i < 6400; i++) step(i % 4 == 3);
    // Random enable pattern.
    for (int i = 0; i < 3000; i++) step(1'($urandom_range(0, 1)));
    // Run into the middle of a small frame, then reset asynchronously.
    for (int i = 0; i < 3000 && ((k / B_HT) % B_VT) != 10; i++) step(1'b1);
    @(posedge Clk);
    if (sys_reset && ce_pix) k++;
    #3;
    sys_reset  = 1'b0;
    k          = 0;
    const_mode = 1'b1;
    #1;
    chk("rst_async_b_pix_y", b_y, 0);
    chk("rst_async_b_pix_x", b_x, 0);
    chk("rst_async_b_blank", {b_hb, b_vb, b_hs, b_vs}, 0);
    chk("rst_async_b_rgb", {b_r, b_g, b_b}, 0);
    chk("rst_async_a_out", {a_hb, a_vb, a_hs, a_vs, a_r, a_g, a_b}, 0);
    repeat (3) step(1'b1);
    @(posedge Clk);
    #1 sys_reset = 1'b1;
    // Renderer held at white after restart.
    for (int i = 0; i < 2000; i++) step(1'b1);

    @(negedge Clk);
    #1;
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
